mvm_ctrl: RTL

- Control/scheduling FSM for the streaming matrix-vector multiply datapath (MAT_SCALE x MAT_SCALE matrix A times vector x).
- Sequences input-memory writes, MAC reads/accumulate controls, y-buffer writes and result streaming.
- Ping-pong input banks let job N+1 load while job N computes, so start can be asserted back-to-back on the last x element.
- Drives address/enable lines only; no arithmetic on data.

---
 rtl/mvm_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mvm_ctrl.sv
// mvm_ctrl: control/scheduling FSMs for the streaming matrix-vector multiply
// datapath. A load FSM fills one of two ping-pong input banks (A then x).
// A compute FSM sweeps the other bank through the MAC, writes y rows, and
// then streams the y buffer out.
// Optional build macro MVM_CTRL_STATS_EN adds the jobs_done/stall_cycles
// counters.
module mvm_ctrl #(
  parameter int MAT_SCALE = 4,
  parameter int PIPE_LAT  = 1,
  parameter int AW_A      = $clog2(MAT_SCALE*MAT_SCALE),
  parameter int AW_X      = $clog2(MAT_SCALE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            ready,
  output logic            start_err,
  output logic            wr_bank,
  output logic            wr_en_a,
  output logic            wr_en_x,
  output logic [AW_A-1:0] addr_a,
  output logic [AW_X-1:0] addr_x,
  output logic            rd_bank,
  output logic [AW_A-1:0] rd_addr_a,
  output logic [AW_X-1:0] rd_addr_x,
  output logic            mac_en,
  output logic            acc_clr,
  output logic            y_wr_en,
  output logic [AW_X-1:0] y_addr,
  output logic            done,
  output logic            out_valid,
  output logic [AW_X-1:0] out_addr
`ifdef MVM_CTRL_STATS_EN
  ,
  output logic [15:0]     jobs_done,
  output logic [15:0]     stall_cycles
`endif
);

  localparam logic [AW_A-1:0] A_LAST = AW_A'(MAT_SCALE*MAT_SCALE-1);
  localparam logic [AW_X-1:0] X_LAST = AW_X'(MAT_SCALE-1);
  localparam logic [2:0]      D_LAST = 3'(PIPE_LAT-1);

  typedef enum logic [1:0] {L_IDLE, L_A, L_X} lstate_t;
  typedef enum logic [2:0] {C_IDLE, C_MAC, C_DRAIN, C_DONE, C_OUT} cstate_t;

  lstate_t l_state, l_next;
  cstate_t c_state, c_next;

  logic            alive;      // low while reset is held so ready/start_err stay 0
  logic [1:0]      bank_full;
  logic            wb, rb;
  logic [AW_A-1:0] a_cnt;
  logic [AW_X-1:0] x_cnt;
  logic [AW_A-1:0] m_cnt;
  logic [AW_X-1:0] k_cnt, r_cnt, o_cnt;
  logic [2:0]      d_cnt;
  logic            last_x, tgt, rdy, accept, full_now;
  logic            src_v;
  logic [AW_X-1:0] src_r;
  logic            pv_reg [PIPE_LAT];
  logic [AW_X-1:0] pr_reg [PIPE_LAT];

  // Handshake: a load may start from idle or chain straight off the final x cycle
  assign last_x    = (l_state == L_X) && (x_cnt == X_LAST);
  assign tgt       = (l_state == L_IDLE) ? wb : ~wb;
  assign rdy       = alive && ((l_state == L_IDLE) || last_x) && !bank_full[tgt];
  assign accept    = start && rdy;
  assign ready     = rdy;
  assign start_err = alive && start && !rdy;
  assign wr_bank   = wb;
  assign rd_bank   = rb;

  // Bank about to be computable, including the one finishing its load this cycle
  assign full_now  = bank_full[rb] || (last_x && (wb == rb));

  // Liveness flag released on the first edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alive <= 1'b0;
    else       alive <= 1'b1;
  end

  // Load FSM state, write counters and bank pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_state <= L_IDLE;
      a_cnt   <= '0;
      x_cnt   <= '0;
      wb      <= 1'b0;
    end else begin
      l_state <= l_next;
      a_cnt   <= (l_state == L_A && a_cnt != A_LAST) ? a_cnt + 1'b1 : '0;
      x_cnt   <= (l_state == L_X && !last_x) ? x_cnt + 1'b1 : '0;
      if (last_x) wb <= ~wb;
    end
  end

  // Load FSM next state and write-side outputs
  always_comb begin
    l_next  = l_state;
    wr_en_a = 1'b0;
    wr_en_x = 1'b0;
    addr_a  = '0;
    addr_x  = '0;
    case (l_state)
      L_IDLE: if (accept) l_next = L_A;
      L_A: begin
        wr_en_a = 1'b1;
        addr_a  = a_cnt;
        if (a_cnt == A_LAST) l_next = L_X;
      end
      L_X: begin
        wr_en_x = 1'b1;
        addr_x  = x_cnt;
        if (last_x) l_next = accept ? L_A : L_IDLE;
      end
      default: l_next = L_IDLE;
    endcase
  end

  // Bank occupancy: released by compute on done, claimed at end of a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      if (c_state == C_DONE) bank_full[rb] <= 1'b0;
      if (last_x)            bank_full[wb] <= 1'b1;
    end
  end

  // Compute FSM state, row/column sweep counters and read bank pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state <= C_IDLE;
      m_cnt   <= '0;
      k_cnt   <= '0;
      r_cnt   <= '0;
      d_cnt   <= '0;
      o_cnt   <= '0;
      rb      <= 1'b0;
    end else begin
      c_state <= c_next;
      m_cnt   <= (c_state == C_MAC && m_cnt != A_LAST) ? m_cnt + 1'b1 : '0;
      if (c_state == C_MAC) begin
        if (k_cnt == X_LAST) begin
          k_cnt <= '0;
          r_cnt <= (r_cnt == X_LAST) ? '0 : r_cnt + 1'b1;
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end else begin
        k_cnt <= '0;
        r_cnt <= '0;
      end
      d_cnt <= (c_state == C_DRAIN && d_cnt != D_LAST) ? d_cnt + 1'b1 : '0;
      o_cnt <= (c_state == C_OUT && o_cnt != X_LAST) ? o_cnt + 1'b1 : '0;
      if (c_state == C_DONE) rb <= ~rb;
    end
  end

  // Compute FSM next state and MAC/result outputs
  always_comb begin
    c_next    = c_state;
    mac_en    = 1'b0;
    acc_clr   = 1'b0;
    rd_addr_a = '0;
    rd_addr_x = '0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    case (c_state)
      C_IDLE: if (full_now) c_next = C_MAC;
      C_MAC: begin
        mac_en    = 1'b1;
        acc_clr   = (k_cnt == '0);
        rd_addr_a = m_cnt;
        rd_addr_x = k_cnt;
        if (m_cnt == A_LAST) c_next = C_DRAIN;
      end
      C_DRAIN: if (d_cnt == D_LAST) c_next = C_DONE;
      C_DONE: begin
        done   = 1'b1;
        c_next = C_OUT;
      end
      C_OUT: begin
        out_valid = 1'b1;
        out_addr  = o_cnt;
        if (o_cnt == X_LAST) c_next = full_now ? C_MAC : C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // Row-complete marker entering the accumulator-latency delay line
  assign src_v = (c_state == C_MAC) && (k_cnt == X_LAST);
  assign src_r = src_v ? r_cnt : '0;

  // (valid,row) delay line matching the MAC pipeline latency
  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_ypipe
    if (gi == 0) begin : g_head
      // First stage captures the row that just finished its last column
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pv_reg[gi] <= 1'b0;
          pr_reg[gi] <= '0;
        end else begin
          pv_reg[gi] <= src_v;
          pr_reg[gi] <= src_r;
        end
      end
    end else begin : g_tail
      // Later stages just shift the marker along
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pv_reg[gi] <= 1'b0;
          pr_reg[gi] <= '0;
        end else begin
          pv_reg[gi] <= pv_reg[gi-1];
          pr_reg[gi] <= pr_reg[gi-1];
        end
      end
    end
  end

  assign y_wr_en = pv_reg[PIPE_LAT-1];
  assign y_addr  = pr_reg[PIPE_LAT-1];

`ifdef MVM_CTRL_STATS_EN
  // Saturating job and stall counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jobs_done    <= '0;
      stall_cycles <= '0;
    end else begin
      if (c_state == C_DONE && jobs_done != 16'hFFFF)
        jobs_done <= jobs_done + 16'd1;
      if ((c_state == C_IDLE || c_state == C_OUT) && bank_full[~rb] &&
          stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
